// File: rtl/rsa_job_arbiter_pkg.sv
// Shared definitions for the rsa4k job arbiter: FSM state codes and
// the default engine timeout.
package rsa_job_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    // Cycles allowed between eng_go and eng_done before the job is aborted.
    localparam logic [23:0] TIMEOUT_DEFAULT = 24'hFF_FFFF;

endpackage

// File: rtl/rsa_job_arbiter_rr_pick.sv
// Round-robin winner search: first set req bit starting at ptr, wrapping
// from NUM_REQ-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic [IDX_W:0] idx;

    // Walk offsets from farthest to nearest so the offset closest to ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = |req;
        idx       = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (idx >= (IDX_W + 1)'(NUM_REQ))
                idx = idx - (IDX_W + 1)'(NUM_REQ);
            if (req[idx[IDX_W-1:0]])
                winner = idx[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one rsa4k engine between NUM_REQ requesters. Round-robin grant,
// one-cycle operand settle, go pulse, bounded wait for done, release.
module rsa_job_arbiter
    import rsa_job_arbiter_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         sel,
    output logic               eng_go,
    input  logic               eng_done,
    output logic [NUM_REQ-1:0] req_done,
    output logic               req_err,
    output logic               busy,
    output logic [15:0]        job_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, owner, owner_nxt, win_idx;
    logic               any_req;
    logic [23:0]        tmo_cnt, tmo_cnt_nxt;
    logic               err, err_nxt;
    logic [NUM_REQ-1:0] owner_oh;
    logic               holding;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .winner    (win_idx),
        .any_valid (any_req)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. Timeout fires on the TIMEOUT-th RUN cycle (counter
    // is 0 in the first RUN cycle), and a coincident done takes priority.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        err_nxt     = err;
        tmo_cnt_nxt = tmo_cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    owner_nxt = win_idx;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: state_nxt = ST_START;
            ST_START: begin
                tmo_cnt_nxt = '0;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (eng_done) begin
                    err_nxt   = 1'b0;
                    state_nxt = ST_RELEASE;
                end else if (tmo_cnt == TIMEOUT - 24'd1) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_RELEASE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 24'd1;
                end
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign owner_oh = ONE << owner_nxt;
    assign holding  = (state_nxt == ST_GRANT) || (state_nxt == ST_START) ||
                      (state_nxt == ST_RUN);

    // Registered outputs and datapath, decoded from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= '0;
            ptr       <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
            gnt       <= '0;
            sel       <= '0;
            eng_go    <= 1'b0;
            req_done  <= '0;
            req_err   <= 1'b0;
            busy      <= 1'b0;
            job_count <= '0;
        end else begin
            owner    <= owner_nxt;
            err      <= err_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            sel      <= 3'(owner_nxt);
            gnt      <= holding ? owner_oh : '0;
            eng_go   <= (state_nxt == ST_START);
            req_done <= (state_nxt == ST_RELEASE) ? owner_oh : '0;
            req_err  <= (state_nxt == ST_RELEASE) && err_nxt;
            busy     <= (state_nxt != ST_IDLE);
            if (state == ST_RUN && state_nxt == ST_RELEASE && !err_nxt)
                job_count <= job_count + 16'd1;
            if (state == ST_RELEASE)
                ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
        end
    end

endmodule
